bp_update_scheduler: RTL and testbench

Sequences resolved-branch updates from the execute/commit stage into `global_branch_predictor`'s single update port (`glob_pred_ld`, `cpu_br_en`, `write_pc`). It buffers outcomes in a small FIFO so the pipeline never waits on the predictor, and issues at most one update per cycle in program order. Issue pauses while the predictor's history must stay frozen. It also keeps saturating branch and mispredict counters for performance monitoring.

---
 rtl/bp_update_scheduler.sv | 132 +++++++++++++
 tb/tb_bp_update_scheduler.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_update_scheduler.sv
// -----------------------------------------------------------------------------
// bp_update_scheduler
//
// Buffers resolved-branch outcomes from execute/commit in a small FIFO. It
// replays them in program order into the global branch predictor's single
// update port, at most one per cycle. Issue pauses while `hold` is high, so
// the predictor history stays frozen. Enqueue keeps running during `hold`.
// Two saturating performance counters track accepted branches and accepted
// mispredicts.
//
// Parameters
//   DEPTH  FIFO entries (power of two, >= 2)
//   CTR_W  width of each performance counter
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   upd_valid       resolved branch offered
//   upd_ready       FIFO can accept (count != DEPTH), from state only
//   upd_pc          PC of the resolved branch
//   upd_taken       actual outcome
//   upd_mispred     prediction was wrong (used only for counting)
//   hold            freeze issue; does not block enqueue
//   ctr_clr         synchronous clear of both counters (wins over increment)
//   pred_ld         one-cycle pulse per update -> glob_pred_ld
//   pred_br_en      outcome of the issued update -> cpu_br_en
//   pred_wpc        PC of the issued update -> write_pc
//   idle            FIFO empty and no update in flight on pred_ld
//   br_count        branches accepted (saturating)
//   mispred_count   accepted branches flagged mispredicted (saturating)
// -----------------------------------------------------------------------------
module bp_update_scheduler #(
  parameter int DEPTH = 4,
  parameter int CTR_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             upd_valid,
  output logic             upd_ready,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  input  logic             upd_mispred,
  input  logic             hold,
  input  logic             ctr_clr,
  output logic             pred_ld,
  output logic             pred_br_en,
  output logic [31:0]      pred_wpc,
  output logic             idle,
  output logic [CTR_W-1:0] br_count,
  output logic [CTR_W-1:0] mispred_count
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [31:0]   mem_pc    [DEPTH];
  logic          mem_taken [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW:0]   count;

  logic push;
  logic pop;

  // Ready depends only on the registered occupancy. A full FIFO refuses the
  // push even when a pop frees a slot in the same cycle.
  assign upd_ready = (count != FULL_CNT);
  assign idle      = (count == '0) && !pred_ld;

  assign push = upd_valid && upd_ready;
  // The pop looks only at the stored occupancy. A push into an empty FIFO
  // therefore always waits one cycle in storage, because nothing bypasses it.
  assign pop  = (count != '0) && !hold;

  // NOTE: the storage array has no reset. Its contents are meaningless until
  // count covers them, so clearing the pointers and count is enough.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[tail]    <= upd_pc;
      mem_taken[tail] <= upd_taken;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples the pre-edge values, and the same-cycle push/pop cases stay
  // consistent.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Issue register. The PC and outcome keep their last issued values between
  // pulses, and only pred_ld returns low.
  always_ff @(posedge clk) begin
    if (rst) begin
      pred_ld    <= 1'b0;
      pred_br_en <= 1'b0;
      pred_wpc   <= '0;
    end else begin
      pred_ld <= pop;
      if (pop) begin
        pred_wpc   <= mem_pc[head];
        pred_br_en <= mem_taken[head];
      end
    end
  end

  // Saturating performance counters. A clear overrides an increment in the
  // same cycle.
  always_ff @(posedge clk) begin
    if (rst || ctr_clr) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else if (push) begin
      if (br_count != '1)
        br_count <= br_count + CTR_W'(1);
      if (upd_mispred && (mispred_count != '1))
        mispred_count <= mispred_count + CTR_W'(1);
    end
  end

endmodule

// File: tb/tb_bp_update_scheduler.sv
// -----------------------------------------------------------------------------
// tb_bp_update_scheduler
//
// Self-checking bench for bp_update_scheduler. A behavioural model holds a
// queue of pending {pc, taken} entries and the expected issue and counter
// state, and it advances once per clock. Each scenario task drives stimulus
// and adds its own checks on top of the per-cycle scoreboard. A second
// instance with CTR_W=4 exercises counter saturation.
// -----------------------------------------------------------------------------
module tb_bp_update_scheduler;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        upd_mispred;
  logic        hold;
  logic        ctr_clr;

  logic        upd_ready,  pred_ld,  pred_br_en,  idle;
  logic [31:0] pred_wpc;
  logic [31:0] br_count,   mispred_count;

  logic        upd_ready4, pred_ld4, pred_br_en4, idle4;
  logic [31:0] pred_wpc4;
  logic [3:0]  br_count4,  mispred_count4;

  bp_update_scheduler #(.DEPTH(DEPTH), .CTR_W(32)) dut (
    .clk(clk), .rst(rst), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_mispred(upd_mispred),
    .hold(hold), .ctr_clr(ctr_clr), .pred_ld(pred_ld), .pred_br_en(pred_br_en),
    .pred_wpc(pred_wpc), .idle(idle), .br_count(br_count),
    .mispred_count(mispred_count)
  );

  bp_update_scheduler #(.DEPTH(DEPTH), .CTR_W(4)) dut4 (
    .clk(clk), .rst(rst), .upd_valid(upd_valid), .upd_ready(upd_ready4),
    .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_mispred(upd_mispred),
    .hold(hold), .ctr_clr(ctr_clr), .pred_ld(pred_ld4), .pred_br_en(pred_br_en4),
    .pred_wpc(pred_wpc4), .idle(idle4), .br_count(br_count4),
    .mispred_count(mispred_count4)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  logic [32:0] m_q[$];          // {pc, taken}
  logic        m_ld;
  logic [31:0] m_wpc;
  logic        m_br;
  longint      m_bc, m_mc;      // unbounded counts; saturation applied on compare
  longint      m_bc4, m_mc4;

  // Observation log filled by the scoreboard
  int          pulses;
  logic [31:0] issued[$];
  bit          last_acc;

  // One clock with the model advanced from the currently driven inputs.
  // Afterwards every output of both instances is compared with the model.
  task automatic cycle();
    bit          acc, pop;
    logic [32:0] e;
    acc = 1'b0;
    if (rst) begin
      m_q.delete();
      m_ld = 1'b0; m_wpc = '0; m_br = 1'b0;
      m_bc = 0; m_mc = 0; m_bc4 = 0; m_mc4 = 0;
    end else begin
      pop  = (m_q.size() != 0) && !hold;
      acc  = upd_valid && (m_q.size() < DEPTH);
      m_ld = pop;
      if (pop) begin
        e = m_q.pop_front();
        m_wpc = e[32:1];
        m_br  = e[0];
      end
      if (acc) m_q.push_back({upd_pc, upd_taken});
      if (ctr_clr) begin
        m_bc = 0; m_mc = 0; m_bc4 = 0; m_mc4 = 0;
      end else if (acc) begin
        if (m_bc < 64'hFFFF_FFFF) m_bc++;
        if (m_bc4 < 15) m_bc4++;
        if (upd_mispred) begin
          if (m_mc < 64'hFFFF_FFFF) m_mc++;
          if (m_mc4 < 15) m_mc4++;
        end
      end
    end
    last_acc = acc;
    @(posedge clk);
    #1;
    checks++;
    if (pred_ld !== m_ld) begin
      failures++; $display("FAIL sb_pred_ld t=%0t got=%b exp=%b", $time, pred_ld, m_ld);
    end
    checks++;
    if (pred_wpc !== m_wpc || pred_br_en !== m_br) begin
      failures++;
      $display("FAIL sb_pred_data t=%0t got=%h/%b exp=%h/%b", $time, pred_wpc, pred_br_en, m_wpc, m_br);
    end
    checks++;
    if (upd_ready !== (m_q.size() < DEPTH) || idle !== (m_q.size() == 0 && !m_ld)) begin
      failures++;
      $display("FAIL sb_ready_idle t=%0t got=%b/%b exp=%b/%b", $time, upd_ready, idle,
               m_q.size() < DEPTH, m_q.size() == 0 && !m_ld);
    end
    checks++;
    if (br_count !== 32'(m_bc) || mispred_count !== 32'(m_mc)) begin
      failures++;
      $display("FAIL sb_counters t=%0t got=%0d/%0d exp=%0d/%0d", $time, br_count, mispred_count, m_bc, m_mc);
    end
    checks++;
    if (pred_ld4 !== m_ld || pred_wpc4 !== m_wpc || pred_br_en4 !== m_br ||
        upd_ready4 !== (m_q.size() < DEPTH) || idle4 !== (m_q.size() == 0 && !m_ld) ||
        br_count4 !== 4'(m_bc4) || mispred_count4 !== 4'(m_mc4)) begin
      failures++;
      $display("FAIL sb_ctr4 t=%0t got ld=%b bc=%0d mc=%0d exp ld=%b bc=%0d mc=%0d",
               $time, pred_ld4, br_count4, mispred_count4, m_ld, m_bc4, m_mc4);
    end
    if (pred_ld) begin
      pulses++;
      issued.push_back(pred_wpc);
    end
  endtask

  task automatic idle_inputs();
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_mispred = 1'b0;
    hold = 1'b0; ctr_clr = 1'b0;
  endtask

  task automatic clear_log();
    pulses = 0;
    issued.delete();
  endtask

  task automatic drain(input int n);
    idle_inputs();
    repeat (n) cycle();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;
    checks++;
    if (pred_ld !== 1'b0 || pred_wpc !== 32'h0 || pred_br_en !== 1'b0) begin
      failures++; $display("FAIL reset_outputs got ld=%b wpc=%h br=%b exp 0/0/0", pred_ld, pred_wpc, pred_br_en);
    end
    checks++;
    if (upd_ready !== 1'b1 || idle !== 1'b1 || br_count !== 32'h0 || mispred_count !== 32'h0) begin
      failures++;
      $display("FAIL reset_status got rdy=%b idle=%b bc=%0d mc=%0d exp 1/1/0/0", upd_ready, idle, br_count, mispred_count);
    end
  endtask

  task automatic test_single();
    int first_pulse;
    clear_log();
    first_pulse = -1;
    upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1;
    cycle();                          // edge N: push
    idle_inputs();
    for (int i = 1; i <= 5; i++) begin
      cycle();
      if (pred_ld && first_pulse < 0) first_pulse = i;
    end
    checks++;
    if (pulses != 1 || first_pulse != 1) begin
      failures++; $display("FAIL single_timing got pulses=%0d at=%0d exp 1 at 1", pulses, first_pulse);
    end
    checks++;
    if (issued.size() != 1 || issued[0] !== 32'h40 || pred_br_en !== 1'b1) begin
      failures++; $display("FAIL single_data got n=%0d br=%b exp pc 40 br 1", issued.size(), pred_br_en);
    end
    else if (idle !== 1'b1) begin
      checks++; failures++; $display("FAIL single_idle got=%b exp=1", idle);
    end
  endtask

  task automatic test_full();
    int idx, accepted, run, best_run;
    bit prev;
    clear_log();
    idx = 0; accepted = 0;
    hold = 1'b1;
    for (int c = 0; c < 8; c++) begin
      upd_valid = 1'b1; upd_pc = 32'(idx * 4); upd_taken = 1'($urandom);
      cycle();
      if (last_acc) begin idx++; accepted++; end
    end
    checks++;
    if (accepted != 4 || upd_ready !== 1'b0) begin
      failures++; $display("FAIL full_backpressure got acc=%0d rdy=%b exp 4/0", accepted, upd_ready);
    end
    hold = 1'b0;
    for (int c = 0; c < 20 && idx < 6; c++) begin
      upd_valid = 1'b1; upd_pc = 32'(idx * 4); upd_taken = 1'($urandom);
      cycle();
      if (last_acc) idx++;
    end
    drain(8);
    checks++;
    if (issued.size() != 6) begin
      failures++; $display("FAIL full_count got=%0d exp=6", issued.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (issued[i] !== 32'(i * 4)) begin
          failures++; $display("FAIL full_order idx=%0d got=%h exp=%h", i, issued[i], i * 4);
        end
      end
    end
    // Recompute the longest pred_ld run through a hold-release sequence.
    clear_log();
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      upd_valid = 1'b1; upd_pc = 32'h100 + 32'(i); cycle();
    end
    idle_inputs();
    run = 0; best_run = 0; prev = 1'b0;
    for (int c = 0; c < 8; c++) begin
      cycle();
      run = pred_ld ? run + 1 : 0;
      if (run > best_run) best_run = run;
      prev = pred_ld;
    end
    checks++;
    if (best_run != 4 || prev !== 1'b0) begin
      failures++; $display("FAIL full_consecutive got run=%0d exp=4", best_run);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] sent[$];
    int over;
    clear_log();
    over = 0;
    for (int i = 0; i < 20; i++) begin
      upd_valid = 1'b1; upd_pc = $urandom & 32'hFFFF_FFFC; upd_taken = 1'($urandom);
      sent.push_back(upd_pc);
      cycle();
      if (dut.count > 1) over++;
    end
    drain(4);
    checks++;
    if (over != 0 || pulses != 20) begin
      failures++; $display("FAIL b2b_count got over=%0d pulses=%0d exp 0/20", over, pulses);
    end
    checks++;
    if (issued != sent) begin
      failures++; $display("FAIL b2b_order got n=%0d exp n=%0d (sequence differs)", issued.size(), sent.size());
    end
  endtask

  task automatic test_hold_mid_drain();
    int  wait_c;
    bit  pat[5];
    clear_log();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      upd_valid = 1'b1; upd_pc = 32'h200 + 32'(i * 4); upd_taken = 1'($urandom); cycle();
    end
    idle_inputs();
    wait_c = 0;
    while (!pred_ld && wait_c < 10) begin cycle(); wait_c++; end
    checks++;
    if (!pred_ld) begin
      failures++; $display("FAIL hold_first_issue got=0 exp=1 (timeout)");
    end
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) hold = 1'b0;
      cycle();
      pat[i] = pred_ld;
    end
    checks++;
    if (pat[0] || pat[1] || !pat[2] || !pat[3] || pat[4]) begin
      failures++; $display("FAIL hold_gap got=%b%b%b%b%b exp=00110", pat[0], pat[1], pat[2], pat[3], pat[4]);
    end
    checks++;
    if (issued.size() != 3 || issued[0] !== 32'h200 || issued[1] !== 32'h204 || issued[2] !== 32'h208) begin
      failures++; $display("FAIL hold_order got n=%0d exp 3 in order 200,204,208", issued.size());
    end
  endtask

  task automatic test_counters();
    int mis_idx[3];
    idle_inputs();
    ctr_clr = 1'b1; cycle(); ctr_clr = 1'b0;
    mis_idx[0] = $urandom_range(0, 3);
    mis_idx[1] = $urandom_range(4, 6);
    mis_idx[2] = $urandom_range(7, 9);
    for (int i = 0; i < 10; i++) begin
      upd_valid = 1'b1; upd_pc = 32'(i * 8); upd_taken = 1'($urandom);
      upd_mispred = (i == mis_idx[0] || i == mis_idx[1] || i == mis_idx[2]);
      cycle();
    end
    idle_inputs();
    checks++;
    if (br_count !== 32'd10 || mispred_count !== 32'd3) begin
      failures++; $display("FAIL ctr_counts got=%0d/%0d exp=10/3", br_count, mispred_count);
    end
    upd_valid = 1'b1; upd_mispred = 1'b1; ctr_clr = 1'b1;
    cycle();
    idle_inputs();
    checks++;
    if (br_count !== 32'd0 || mispred_count !== 32'd0) begin
      failures++; $display("FAIL ctr_clr_wins got=%0d/%0d exp=0/0", br_count, mispred_count);
    end
    drain(4);
    for (int i = 0; i < 17; i++) begin
      upd_valid = 1'b1; upd_pc = 32'(i); upd_mispred = 1'b1; cycle();
    end
    idle_inputs();
    checks++;
    if (br_count4 !== 4'd15 || mispred_count4 !== 4'd15 || br_count !== 32'd17) begin
      failures++; $display("FAIL ctr_saturate got=%0d/%0d/%0d exp=15/15/17", br_count4, mispred_count4, br_count);
    end
    drain(4);
  endtask

  task automatic test_reset_mid();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      upd_valid = 1'b1; upd_pc = 32'h300 + 32'(i); upd_mispred = 1'b1; cycle();
    end
    idle_inputs();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    clear_log();
    repeat (6) cycle();
    checks++;
    if (pulses != 0) begin
      failures++; $display("FAIL rst_mid_pulses got=%0d exp=0", pulses);
    end
    checks++;
    if (idle !== 1'b1 || upd_ready !== 1'b1 || br_count !== 32'd0 || mispred_count !== 32'd0) begin
      failures++;
      $display("FAIL rst_mid_status got idle=%b rdy=%b bc=%0d mc=%0d exp 1/1/0/0", idle, upd_ready, br_count, mispred_count);
    end
  endtask

  task automatic test_random();
    logic [32:0] exp_all[$];
    int          n_acc;
    clear_log();
    n_acc = 0;
    for (int i = 0; i < 400; i++) begin
      upd_valid   = ($urandom_range(0, 3) != 0);
      upd_pc      = $urandom;
      upd_taken   = 1'($urandom);
      upd_mispred = 1'($urandom);
      hold        = ($urandom_range(0, 3) == 0);
      ctr_clr     = ($urandom_range(0, 40) == 0);
      cycle();
      if (last_acc) n_acc++;
    end
    drain(8);
    checks++;
    if (pulses != n_acc) begin
      failures++; $display("FAIL rand_conservation got pulses=%0d exp=%0d", pulses, n_acc);
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    m_ld = 1'b0; m_wpc = '0; m_br = 1'b0;
    m_bc = 0; m_mc = 0; m_bc4 = 0; m_mc4 = 0;
    clear_log();
    #2;
    test_reset();
    test_single();
    test_full();
    test_back_to_back();
    test_hold_mid_drain();
    test_counters();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
